riscv_crypto_aes128_ks_seq: RTL and testbench

//  AES-128 key-expansion sequencer that sits upstream of the saes64 FU and

---
 rtl/riscv_crypto_aes128_ks_seq_pkg.sv | 21 ++
 rtl/riscv_crypto_aes128_ks_seq.sv | 180 ++++++++++++++++++
 tb/tb_riscv_crypto_aes128_ks_seq.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_crypto_aes128_ks_seq_pkg.sv
// riscv_crypto_aes128_ks_seq_pkg: state encodings and round constants for the AES-128 key-schedule sequencer.
package riscv_crypto_aes128_ks_seq_pkg;

    localparam logic [3:0] AES128_ROUNDS = 4'd10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EMIT,
        ST_KS1,
        ST_KS2A,
        ST_KS2B,
        ST_IMX0,
        ST_IMX1
    } ks_state_e;

    // Only the inner round keys of the equivalent inverse cipher pass through InvMixColumns.
    function automatic logic uses_imix(input logic dec, input logic [3:0] round);
        return dec && round != 4'd0 && round != AES128_ROUNDS;
    endfunction

endpackage

// File: rtl/riscv_crypto_aes128_ks_seq.sv
// riscv_crypto_aes128_ks_seq: drives an external saes64 FU through ks1/ks2/imix to stream AES-128 round keys 0..10.
module riscv_crypto_aes128_ks_seq
    import riscv_crypto_aes128_ks_seq_pkg::*;
#(
    parameter bit IMIX_EN = 1'b1
) (
    input  logic         g_clk,
    input  logic         g_resetn,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key,
    input  logic         key_dec,
    input  logic         abort,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_index,
    output logic         rk_last,
    output logic         fu_valid,
    input  logic         fu_ready,
    output logic [63:0]  fu_rs1,
    output logic [63:0]  fu_rs2,
    output logic [3:0]   fu_enc_rcon,
    output logic         fu_op_ks1,
    output logic         fu_op_ks2,
    output logic         fu_op_imix,
    input  logic [63:0]  fu_rd
);

    ks_state_e      state_q, state_d;
    logic [3:0]     round_q, round_d;
    logic [63:0]    k0_q, k0_d, k1_q, k1_d, t_q, t_d, o0_q, o0_d, o1_q, o1_d;
    logic           dec_q, dec_d;
    logic           key_ready_q, key_ready_d, rk_valid_q, rk_valid_d, rk_last_q, rk_last_d;
    logic [127:0]   rk_data_q, rk_data_d;
    logic [3:0]     rk_index_q, rk_index_d, rcon_q, rcon_d;
    logic           fu_valid_q, fu_valid_d, ks1_q, ks1_d, ks2_q, ks2_d, imix_q, imix_d;
    logic [63:0]    rs1_q, rs1_d, rs2_q, rs2_d;
    logic           fu_fire, rk_fire;

    assign fu_fire = fu_valid_q && fu_ready;
    assign rk_fire = rk_valid_q && rk_ready;

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        k0_d    = k0_q;
        k1_d    = k1_q;
        t_d     = t_q;
        dec_d   = dec_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (key_valid && key_ready_q) begin
                    k0_d    = key[63:0];
                    k1_d    = key[127:64];
                    dec_d   = key_dec && IMIX_EN;
                    round_d = '0;
                    state_d = ST_EMIT;
                end
                ST_EMIT: if (rk_fire) state_d = (round_q == AES128_ROUNDS) ? ST_IDLE : ST_KS1;
                ST_KS1:  if (fu_fire) begin
                    t_d     = fu_rd;
                    state_d = ST_KS2A;
                end
                ST_KS2A: if (fu_fire) begin
                    k0_d    = fu_rd;
                    state_d = ST_KS2B;
                end
                ST_KS2B: if (fu_fire) begin
                    k1_d    = fu_rd;
                    round_d = round_q + 4'd1;
                    state_d = uses_imix(dec_q, round_q + 4'd1) ? ST_IMX0 : ST_EMIT;
                end
                ST_IMX0: if (fu_fire) state_d = ST_IMX1;
                ST_IMX1: if (fu_fire) state_d = ST_EMIT;
                default: state_d = ST_IDLE;
            endcase
        end
        // Outputs are registered from the next state so they are glitch-free and hold through stalls.
        key_ready_d = state_d == ST_IDLE;
        rk_valid_d  = state_d == ST_EMIT;
        rk_index_d  = rk_valid_d ? round_d : '0;
        rk_last_d   = rk_valid_d && round_d == AES128_ROUNDS;
        rk_data_d   = !rk_valid_d ? '0 : uses_imix(dec_d, round_d) ? {o1_d, o0_d} : {k1_d, k0_d};
        ks1_d       = state_d == ST_KS1;
        ks2_d       = state_d == ST_KS2A || state_d == ST_KS2B;
        imix_d      = state_d == ST_IMX0 || state_d == ST_IMX1;
        fu_valid_d  = ks1_d || ks2_d || imix_d;
        rs1_d       = ks1_d ? k1_d :
                      state_d == ST_KS2A ? t_d :
                      (state_d == ST_KS2B || state_d == ST_IMX0) ? k0_d :
                      state_d == ST_IMX1 ? k1_d : '0;
        rs2_d       = state_d == ST_KS2A ? k0_d : state_d == ST_KS2B ? k1_d : '0;
        rcon_d      = ks1_d ? round_d : '0;
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q <= ST_IDLE;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            k0_q        <= '0;
            k1_q        <= '0;
            t_q         <= '0;
            dec_q       <= 1'b0;
            key_ready_q <= 1'b0;
            rk_valid_q  <= 1'b0;
            rk_data_q   <= '0;
            rk_index_q  <= '0;
            rk_last_q   <= 1'b0;
            fu_valid_q  <= 1'b0;
            ks1_q       <= 1'b0;
            ks2_q       <= 1'b0;
            imix_q      <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rcon_q      <= '0;
        end else begin
            k0_q        <= k0_d;
            k1_q        <= k1_d;
            t_q         <= t_d;
            dec_q       <= dec_d;
            key_ready_q <= key_ready_d;
            rk_valid_q  <= rk_valid_d;
            rk_data_q   <= rk_data_d;
            rk_index_q  <= rk_index_d;
            rk_last_q   <= rk_last_d;
            fu_valid_q  <= fu_valid_d;
            ks1_q       <= ks1_d;
            ks2_q       <= ks2_d;
            imix_q      <= imix_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rcon_q      <= rcon_d;
        end
    end

    if (IMIX_EN) begin : g_imix
        assign o0_d = (!abort && state_q == ST_IMX0 && fu_fire) ? fu_rd : o0_q;
        assign o1_d = (!abort && state_q == ST_IMX1 && fu_fire) ? fu_rd : o1_q;
        always_ff @(posedge g_clk or negedge g_resetn) begin
            if (!g_resetn) begin
                o0_q <= '0;
                o1_q <= '0;
            end else begin
                o0_q <= o0_d;
                o1_q <= o1_d;
            end
        end
    end else begin : g_no_imix
        assign o0_d = '0;
        assign o1_d = '0;
        assign o0_q = '0;
        assign o1_q = '0;
    end

    // abort withdraws both requests in the same cycle it is raised.
    assign key_ready   = key_ready_q;
    assign rk_valid    = rk_valid_q && !abort;
    assign rk_data     = rk_data_q;
    assign rk_index    = rk_index_q;
    assign rk_last     = rk_last_q;
    assign fu_valid    = fu_valid_q && !abort;
    assign fu_rs1      = rs1_q;
    assign fu_rs2      = rs2_q;
    assign fu_enc_rcon = rcon_q;
    assign fu_op_ks1   = ks1_q;
    assign fu_op_ks2   = ks2_q;
    assign fu_op_imix  = imix_q;

endmodule

// File: tb/tb_riscv_crypto_aes128_ks_seq.sv
// tb_riscv_crypto_aes128_ks_seq: behavioural saes64 FU plus scoreboard of expected round keys for the sequencer.
module tb_riscv_crypto_aes128_ks_seq;

    logic         g_clk = 1'b0;
    logic         g_resetn = 1'b1;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [127:0] key = '0;
    logic         key_dec = 1'b0;
    logic         abort = 1'b0;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_index;
    logic         rk_last;
    logic         fu_valid;
    logic         fu_ready;
    logic [63:0]  fu_rs1, fu_rs2, fu_rd;
    logic [3:0]   fu_enc_rcon;
    logic         fu_op_ks1, fu_op_ks2, fu_op_imix;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] data;
        logic         last;
    } rk_t;
    rk_t          exp_q[$];
    logic [127:0] ref_rk [0:10];
    logic [127:0] got_rk [0:10];

    bit stall_mode = 1'b0;
    bit rk_hold = 1'b0;
    bit fu_force = 1'b0;
    int fu_wait = 0;
    int rk_wait = 0;

    always #5 g_clk = ~g_clk;

    riscv_crypto_aes128_ks_seq dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .key_valid(key_valid), .key_ready(key_ready), .key(key), .key_dec(key_dec), .abort(abort),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data), .rk_index(rk_index), .rk_last(rk_last),
        .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_rs1(fu_rs1), .fu_rs2(fu_rs2), .fu_enc_rcon(fu_enc_rcon),
        .fu_op_ks1(fu_op_ks1), .fu_op_ks2(fu_op_ks2), .fu_op_imix(fu_op_imix), .fu_rd(fu_rd)
    );

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, p;
        r = 8'h00;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ p;
            p = xt(p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [7:0] p, r;
        p = x;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gm(p, p);
            r = gm(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 16; i++) if (i < int'(n)) r = xt(r);
        return (n > 4'd9) ? 8'h00 : r;
    endfunction

    function automatic logic [31:0] imc(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a3, a2, a1, a0} = w;
        return {gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e),
                gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b),
                gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d),
                gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09)};
    endfunction

    function automatic logic [63:0] im64(input logic [63:0] x);
        return {imc(x[63:32]), imc(x[31:0])};
    endfunction

    function automatic logic [63:0] ks1(input logic [63:0] rs1, input logic [3:0] rn);
        logic [31:0] w;
        w = rs1[63:32];
        if (rn != 4'hA) w = {w[7:0], w[31:8]};
        w = subw(w) ^ {24'h0, rcon(rn)};
        return {w, w};
    endfunction

    function automatic logic [63:0] ks2(input logic [63:0] rs1, input logic [63:0] rs2);
        logic [31:0] w0;
        w0 = rs1[63:32] ^ rs2[31:0];
        return {w0 ^ rs2[63:32], w0};
    endfunction

    function automatic logic [127:0] bswap(input logic [127:0] x);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = x[8*(15-i) +: 8];
        return r;
    endfunction

    always_comb fu_rd = fu_op_ks1 ? ks1(fu_rs1, fu_enc_rcon) :
                        fu_op_ks2 ? ks2(fu_rs1, fu_rs2) :
                        fu_op_imix ? im64(fu_rs1) : 64'h0;

    assign fu_ready = fu_force || (fu_valid && fu_wait == 0);
    assign rk_ready = !rk_hold && (!stall_mode || rk_wait == 0);

    always @(posedge g_clk) begin
        fu_wait <= (!fu_valid || fu_ready) ? (stall_mode ? int'($urandom_range(0, 5)) : 0) : fu_wait - 1;
        rk_wait <= (!rk_valid || rk_ready) ? (stall_mode ? int'($urandom_range(0, 5)) : 0) : rk_wait - 1;
    end

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic         pv_rk_valid = 1'b0, pv_rk_ready = 1'b0, pv_fu_valid = 1'b0, pv_fu_ready = 1'b0, pv_abort = 1'b0;
    logic [132:0] pv_rk;
    logic [134:0] pv_fu;
    rk_t          mon_e;

    always @(negedge g_clk) begin
        if (!g_resetn) begin
            pv_rk_valid <= 1'b0;
            pv_fu_valid <= 1'b0;
        end else begin
            if (rk_valid && rk_ready) begin
                check("sb_nonempty", 160'(exp_q.size() > 0), 160'd1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("rk_index", 160'(rk_index), 160'(mon_e.idx));
                    check("rk_data", 160'(rk_data), 160'(mon_e.data));
                    check("rk_last", 160'(rk_last), 160'(mon_e.last));
                end
                got_rk[rk_index] = rk_data;
            end
            if (pv_rk_valid && !pv_rk_ready && rk_valid)
                check("rk_stable", 160'({rk_data, rk_index, rk_last}), 160'(pv_rk));
            if (pv_fu_valid && !pv_fu_ready && !pv_abort && fu_valid)
                check("fu_stable", 160'({fu_rs1, fu_rs2, fu_enc_rcon, fu_op_ks1, fu_op_ks2, fu_op_imix}), 160'(pv_fu));
            if (fu_valid)
                check("fu_op_onehot", 160'($onehot({fu_op_ks1, fu_op_ks2, fu_op_imix})), 160'd1);
            if (fu_valid && fu_op_ks1)
                check("rcon_range", 160'(fu_enc_rcon <= 4'd9), 160'd1);
            pv_rk_valid <= rk_valid;
            pv_rk_ready <= rk_ready;
            pv_fu_valid <= fu_valid;
            pv_fu_ready <= fu_ready;
            pv_abort    <= abort;
            pv_rk       <= {rk_data, rk_index, rk_last};
            pv_fu       <= {fu_rs1, fu_rs2, fu_enc_rcon, fu_op_ks1, fu_op_ks2, fu_op_imix};
        end
    end

    task automatic push_exp(input logic [127:0] k, input logic d);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        rk_t e;
        for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) tmp = subw({tmp[7:0], tmp[31:8]}) ^ {24'h0, rcon(4'(i/4 - 1))};
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) begin
            ref_rk[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
            e.idx  = 4'(r);
            e.data = (d && r >= 1 && r <= 9) ? {im64(ref_rk[r][127:64]), im64(ref_rk[r][63:0])} : ref_rk[r];
            e.last = (r == 10);
            exp_q.push_back(e);
        end
    endtask

    task automatic start_key(input logic [127:0] k, input logic d, input bit hold);
        int n;
        push_exp(k, d);
        key = k;
        key_dec = d;
        key_valid = 1'b1;
        n = 0;
        do begin
            @(negedge g_clk);
            n++;
        end while (!key_ready && n < 100);
        check("key_ready_seen", 160'(key_ready), 160'd1);
        @(posedge g_clk);
        #1;
        key_valid = hold;
        check("rk0_latency", 160'({rk_valid, rk_index, key_ready}), 160'({1'b1, 4'd0, 1'b0}));
    endtask

    task automatic wait_done(input int exp_n);
        int n;
        n = 0;
        do begin
            @(posedge g_clk);
            #1;
            n++;
        end while (!key_ready && n < 400);
        if (exp_n != 0) check("cycles", 160'(n), 160'(exp_n));
        else check("done_in_budget", 160'(n < 400), 160'd1);
        check("sb_drained", 160'(exp_q.size()), 160'd0);
    endtask

    task automatic reset_release();
        @(posedge g_clk);
        @(posedge g_clk);
        @(negedge g_clk);
        g_resetn = 1'b1;
        #1;
        check("key_ready_before_clk", 160'(key_ready), 160'd0);
        @(posedge g_clk);
        #1;
        check("key_ready_after_clk", 160'(key_ready), 160'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] fips_key, fips_rk1, fips_rk10, rkey;
        int n;
        fips_key  = bswap(128'h2b7e151628aed2a6abf7158809cf4f3c);
        fips_rk1  = bswap(128'ha0fafe1788542cb123a339392a6c7605);
        fips_rk10 = bswap(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        #1 g_resetn = 1'b0;
        #1;
        check("reset_rk_side", 160'({key_ready, rk_valid, rk_data, rk_index, rk_last}), 160'd0);
        check("reset_fu_side", 160'({fu_valid, fu_rs1, fu_rs2, fu_enc_rcon, fu_op_ks1, fu_op_ks2, fu_op_imix}), 160'd0);
        reset_release();

        start_key(fips_key, 1'b0, 1'b0);
        wait_done(41);
        check("fips_rk0", 160'(got_rk[0]), 160'(fips_key));
        check("fips_rk1", 160'(got_rk[1]), 160'(fips_rk1));
        check("fips_rk10", 160'(got_rk[10]), 160'(fips_rk10));

        start_key(fips_key, 1'b1, 1'b0);
        wait_done(59);
        check("dec_rk10", 160'(got_rk[10]), 160'(fips_rk10));

        stall_mode = 1'b1;
        start_key(fips_key, 1'b0, 1'b0);
        wait_done(0);
        start_key(fips_key, 1'b1, 1'b0);
        wait_done(0);
        start_key({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
        wait_done(0);
        stall_mode = 1'b0;
        #1;

        // A key offered together with abort in IDLE must be ignored.
        key_valid = 1'b1;
        abort = 1'b1;
        @(posedge g_clk);
        #1;
        check("abort_idle", 160'({key_ready, rk_valid}), 160'(2'b10));
        abort = 1'b0;
        key_valid = 1'b0;

        start_key(fips_key, 1'b0, 1'b0);
        n = 0;
        while (!(rk_valid && rk_index == 4'd4) && n < 100) begin
            @(posedge g_clk);
            #1;
            n++;
        end
        check("reach_rk4", 160'(rk_valid && rk_index == 4'd4), 160'd1);
        @(posedge g_clk);
        #1;
        @(posedge g_clk);
        #1;
        check("ks2a_round4", 160'({fu_valid, fu_op_ks2, fu_rs2}), 160'({1'b1, 1'b1, ref_rk[4][63:0]}));
        abort = 1'b1;
        fu_force = 1'b1;
        #1;
        check("abort_drop_valids", 160'({fu_valid, rk_valid}), 160'd0);
        @(posedge g_clk);
        #1;
        abort = 1'b0;
        fu_force = 1'b0;
        check("abort_k0_kept", 160'(dut.k0_q), 160'(ref_rk[4][63:0]));
        check("abort_to_idle", 160'({key_ready, fu_valid, rk_valid}), 160'(3'b100));
        exp_q.delete();
        start_key({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        wait_done(41);

        // Second key waits on key_valid through the whole first expansion.
        start_key(fips_key, 1'b0, 1'b1);
        rkey = {$urandom, $urandom, $urandom, $urandom};
        key = rkey;
        key_dec = 1'b1;
        wait_done(41);
        push_exp(rkey, 1'b1);
        @(posedge g_clk);
        #1;
        check("held_key_accept", 160'({rk_valid, rk_index, key_ready}), 160'({1'b1, 4'd0, 1'b0}));
        key_valid = 1'b0;
        wait_done(59);

        start_key(fips_key, 1'b1, 1'b0);
        n = 0;
        while (!(rk_valid && rk_index == 4'd7) && n < 100) begin
            @(posedge g_clk);
            #1;
            n++;
        end
        rk_hold = 1'b1;
        check("reach_rk7", 160'(rk_valid && rk_index == 4'd7), 160'd1);
        #2;
        g_resetn = 1'b0;
        #1;
        check("async_rst_rk_side", 160'({key_ready, rk_valid, rk_data, rk_index, rk_last}), 160'd0);
        check("async_rst_fu_side", 160'({fu_valid, fu_rs1, fu_rs2, fu_enc_rcon, fu_op_ks1, fu_op_ks2, fu_op_imix}), 160'd0);
        exp_q.delete();
        rk_hold = 1'b0;
        reset_release();

        start_key({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        wait_done(41);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
